// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  // Fetch FSM states. IDLE only exists for the first cycle after reset.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  // Every instruction is one 32-bit word; the PC advances by this many bytes.
  localparam int WORD_BYTES = 4;

  // PC loaded on reset unless the instantiation overrides it.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {inst, pc} holding register used when ID stalls while a
// fetch completes. clear wins over load so a flush cannot be undone.
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              load,
  input  logic              clear,
  input  logic [INST_W-1:0] load_inst,
  input  logic [ADDR_W-1:0] load_pc,
  output logic              valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] pc
);

  logic              valid_reg;
  logic [INST_W-1:0] inst_reg;
  logic [ADDR_W-1:0] pc_reg;

  // Capture a parked instruction, or drop it on flush / hand-off.
  always_ff @(posedge clk) begin
    if (srst) begin
      valid_reg <= 1'b0;
      inst_reg  <= '0;
      pc_reg    <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      inst_reg  <= load_inst;
      pc_reg    <= load_pc;
    end
  end

  assign valid = valid_reg;
  assign inst  = inst_reg;
  assign pc    = pc_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues one word fetch at a time
// over a req/ready handshake, parks one instruction while ID stalls and
// squashes wrong-path fetches on an EX-stage branch redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              CLK,
  input  logic              CLR,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc4
);

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(WORD_BYTES - 1));

  fetch_state_t      state_reg;
  logic              req_reg;
  logic [ADDR_W-1:0] pc_reg;
  // Address of a request that is being drained after a redirect; pc_reg
  // already points at the branch target by then.
  logic [ADDR_W-1:0] drop_addr_reg;

  logic              if_valid_reg;
  logic [INST_W-1:0] if_inst_reg;
  logic [ADDR_W-1:0] if_pc_reg;
  logic [ADDR_W-1:0] if_pc4_reg;

  logic              slot_free;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] redirect_target;

  logic              skid_load;
  logic              skid_clear;
  logic              skid_valid;
  logic [INST_W-1:0] skid_inst;
  logic [ADDR_W-1:0] skid_pc;

  // ID can accept a new instruction when nothing is presented or it is not stalled.
  assign slot_free       = !if_valid_reg || !stall;
  // Wraps modulo 2^ADDR_W by construction.
  assign pc_next         = pc_reg + STEP;
  assign redirect_target = redirect_pc & ALIGN_MASK;

  // Park the returning word when the output slot is occupied and held.
  assign skid_load  = (state_reg == FETCH) && imem_ready && !redirect && !slot_free;
  // Flush on redirect, or release once the parked word moves to the outputs.
  assign skid_clear = redirect || ((state_reg == HOLD) && slot_free);

  fetch_skid_buffer #(
    .ADDR_W(ADDR_W),
    .INST_W(INST_W)
  ) u_skid (
    .clk       (CLK),
    .srst      (CLR),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_inst (imem_rdata),
    .load_pc   (pc_reg),
    .valid     (skid_valid),
    .inst      (skid_inst),
    .pc        (skid_pc)
  );

  // Fetch FSM with registered request, PC update and the IF/ID output slot.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_reg     <= IDLE;
      req_reg       <= 1'b0;
      pc_reg        <= RESET_PC;
      drop_addr_reg <= '0;
      if_valid_reg  <= 1'b0;
      if_inst_reg   <= '0;
      if_pc_reg     <= '0;
      if_pc4_reg    <= '0;
    end else if (redirect) begin
      // Redirect beats stall and returning data: everything in flight is wrong-path.
      if_valid_reg <= 1'b0;
      pc_reg       <= redirect_target;
      req_reg      <= 1'b1;
      if (((state_reg == FETCH) || (state_reg == DROP)) && !imem_ready) begin
        // A request is still open; keep its address until memory answers.
        state_reg <= DROP;
      end else begin
        state_reg <= FETCH;
      end
      if (state_reg == FETCH) begin
        drop_addr_reg <= pc_reg;
      end
    end else begin
      // ID consumes the presented instruction unless something refills the slot below.
      if (slot_free) begin
        if_valid_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          state_reg <= FETCH;
          req_reg   <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            pc_reg <= pc_next;
            if (slot_free) begin
              if_valid_reg <= 1'b1;
              if_inst_reg  <= imem_rdata;
              if_pc_reg    <= pc_reg;
              if_pc4_reg   <= pc_next;
            end else begin
              state_reg <= HOLD;
              req_reg   <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (slot_free) begin
            if_valid_reg <= skid_valid;
            if_inst_reg  <= skid_inst;
            if_pc_reg    <= skid_pc;
            if_pc4_reg   <= skid_pc + STEP;
            state_reg    <= FETCH;
            req_reg      <= 1'b1;
          end
        end
        DROP: begin
          if (imem_ready) begin
            state_reg <= FETCH;
          end
        end
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = req_reg;
  assign imem_addr = (state_reg == DROP) ? drop_addr_reg : pc_reg;
  assign if_valid  = if_valid_reg;
  assign if_inst   = if_inst_reg;
  assign if_pc     = if_pc_reg;
  assign if_pc4    = if_pc4_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized stall,
// redirect and memory latency, checked by a scoreboard monitor that predicts
// the in-order instruction stream ID should receive.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  fetch_stage #(
    .ADDR_W   (32),
    .INST_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .if_pc4      (if_pc4)
  );

  // Program image: a fixed word at 0, an address hash everywhere else.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hE3A0_1001;
    return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  // Instruction memory: fixed or random wait states, data only on ready.
  int cnt = 0;
  int fixed_wait = 0;
  int cur_wait = 0;
  bit rand_wait = 1'b0;
  initial begin
    imem_ready = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (imem_req) begin
        if (cnt >= (rand_wait ? cur_wait : fixed_wait)) begin
          imem_ready = 1'b1;
          imem_rdata = mem_word(imem_addr);
          cnt        = 0;
          cur_wait   = $urandom_range(0, 3);
        end else begin
          imem_ready = 1'b0;
          imem_rdata = $urandom;
          cnt++;
        end
      end else begin
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        cnt        = 0;
      end
    end
  end

  // Scoreboard: redirect targets issued by the stimulus, consumed by the monitor.
  logic [31:0] redir_q[$];
  bit          mon_en = 1'b0;
  int          deliveries = 0;

  // Monitor: delivered stream must be contiguous words from the latest target.
  initial begin
    logic [31:0] exp_pc;
    logic [31:0] h_inst, h_pc, h_pc4, w_addr;
    bit synced, p_hold, p_redir, p_wait;
    exp_pc = '0; h_inst = '0; h_pc = '0; h_pc4 = '0; w_addr = '0;
    synced = 1'b0; p_hold = 1'b0; p_redir = 1'b0; p_wait = 1'b0;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (p_hold) begin
          chk("stall_hold_valid", 32'(if_valid), 32'd1);
          chk("stall_hold_inst", if_inst, h_inst);
          chk("stall_hold_pc", if_pc, h_pc);
          chk("stall_hold_pc4", if_pc4, h_pc4);
        end
        if (p_redir) chk("flush_valid", 32'(if_valid), 32'd0);
        if (p_wait) begin
          chk("req_held", 32'(imem_req), 32'd1);
          chk("addr_held", imem_addr, w_addr);
        end
        if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
        if (redirect) begin
          if (redir_q.size() == 0) begin
            chk("redir_queue_underflow", 32'd1, 32'd0);
          end else begin
            exp_pc = redir_q.pop_front() & ~32'h3;
            synced = 1'b1;
          end
        end else if (synced && if_valid && !stall) begin
          chk("deliver_pc", if_pc, exp_pc);
          chk("deliver_inst", if_inst, mem_word(exp_pc));
          chk("deliver_pc4", if_pc4, exp_pc + 32'd4);
          exp_pc = exp_pc + 32'd4;
          deliveries++;
        end
        p_hold  = if_valid && stall && !redirect;
        h_inst  = if_inst;
        h_pc    = if_pc;
        h_pc4   = if_pc4;
        p_redir = redirect;
        p_wait  = imem_req && !imem_ready;
        w_addr  = imem_addr;
      end else begin
        p_hold = 1'b0; p_redir = 1'b0; p_wait = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    CLR = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick(); tick(); tick();
    mid();
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_pc4", if_pc4, 32'd0);

    // Zero-wait memory: first instruction two edges after reset release.
    tick(); CLR = 1'b0;
    mid(); chk("idle_req", 32'(imem_req), 32'd0);
    tick();
    mid(); chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid_low", 32'(if_valid), 32'd0);
    tick();
    mid(); chk("i0_valid", 32'(if_valid), 32'd1);
    chk("i0_pc", if_pc, 32'h0);
    chk("i0_pc4", if_pc4, 32'h4);
    chk("i0_inst", if_inst, 32'hE3A0_1001);
    chk("i0_next_addr", imem_addr, 32'h4);
    tick();
    mid(); chk("i1_pc", if_pc, 32'h4);
    chk("i1_inst", if_inst, mem_word(32'h4));

    // Stall for three edges while memory keeps answering.
    tick(); stall = 1'b1;
    mid(); chk("i2_pc", if_pc, 32'h8);
    chk("i2_addr", imem_addr, 32'hC);
    tick();
    mid(); chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_pc_a", if_pc, 32'h8);
    chk("hold_valid", 32'(if_valid), 32'd1);
    tick();
    mid(); chk("hold_pc_b", if_pc, 32'h8);
    tick(); stall = 1'b0;
    mid(); chk("hold_pc_c", if_pc, 32'h8);
    chk("hold_req_c", 32'(imem_req), 32'd0);
    tick();
    mid(); chk("skid_pc", if_pc, 32'hC);
    chk("skid_inst", if_inst, mem_word(32'hC));
    chk("after_skid_addr", imem_addr, 32'h10);
    chk("after_skid_req", 32'(imem_req), 32'd1);
    tick();
    mid(); chk("post_skid_pc", if_pc, 32'h10);
    fixed_wait = 3;

    // Three wait states, redirect on the second wait cycle.
    tick();
    mid(); chk("pre_wait_pc", if_pc, 32'h14);
    chk("wait_addr", imem_addr, 32'h18);
    tick(); redirect = 1'b1; redirect_pc = 32'h103;
    tick(); redirect = 1'b0;
    mid(); chk("drop_valid", 32'(if_valid), 32'd0);
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_addr", imem_addr, 32'h18);
    tick();
    mid(); chk("drop_addr_ready", imem_addr, 32'h18);
    fixed_wait = 0;
    tick();
    mid(); chk("target_addr", imem_addr, 32'h100);
    chk("target_valid_low", 32'(if_valid), 32'd0);

    // Redirect together with ready while stalled.
    tick(); stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    mid(); chk("t0_valid", 32'(if_valid), 32'd1);
    chk("t0_pc", if_pc, 32'h100);
    chk("t0_inst", if_inst, mem_word(32'h100));
    tick(); stall = 1'b0; redirect = 1'b0;
    mid(); chk("flush2_valid", 32'(if_valid), 32'd0);
    chk("flush2_addr", imem_addr, 32'h200);

    // PC wrap at the top of the address space.
    tick(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    mid(); chk("t1_pc", if_pc, 32'h200);
    chk("t1_inst", if_inst, mem_word(32'h200));
    tick(); redirect = 1'b0;
    mid(); chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    mid(); chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_pc4, 32'h0);
    chk("wrap_next_addr", imem_addr, 32'h0);
    fixed_wait = 3;
    tick(); redirect = 1'b1; redirect_pc = 32'h300;
    mid(); chk("wrapped_pc", if_pc, 32'h0);
    chk("wrapped_pc4", if_pc4, 32'h4);

    // Reset while a dropped request is still outstanding.
    tick(); redirect = 1'b0; CLR = 1'b1;
    mid(); chk("drop2_req", 32'(imem_req), 32'd1);
    chk("drop2_addr", imem_addr, 32'h4);
    tick(); CLR = 1'b0;
    mid(); chk("clr_req", 32'(imem_req), 32'd0);
    chk("clr_valid", 32'(if_valid), 32'd0);
    chk("clr_if_pc", if_pc, 32'h0);
    fixed_wait = 0;
    tick();
    mid(); chk("clr_fetch_addr", imem_addr, 32'h0);
    chk("clr_fetch_req", 32'(imem_req), 32'd1);

    // Randomized traffic against the scoreboard.
    rand_wait = 1'b1;
    mon_en    = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      stall = ($urandom_range(0, 3) == 0);
      if (i == 0 || $urandom_range(0, 15) == 0) begin
        redirect = 1'b1;
        if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else redirect_pc = $urandom;
        redir_q.push_back(redirect_pc);
      end else begin
        redirect = 1'b0;
      end
    end
    tick(); stall = 1'b0; redirect = 1'b0;
    repeat (10) tick();
    mid();
    mon_en = 1'b0;
    chk("progress", 32'(deliveries >= 200), 32'd1);
    chk("redir_queue_drained", 32'(redir_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
